// File: rtl/gng_burst_ctrl.sv
// Burst sequencer for the gng noise generator: credit-gated ce, output FIFO, valid/ready stream.
// Define GNG_WARMUP_EN to discard WARMUP samples after reset before the first request.
module gng_burst_ctrl #(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16,
  parameter int WARMUP     = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LEN_W-1:0] req_len,
  input  logic             abort,
  output logic             gng_ce,
  input  logic             gng_valid,
  input  logic [15:0]      gng_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [15:0]      m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (FIFO_DEPTH > WARMUP) ? FIFO_DEPTH : WARMUP;
  localparam int IW   = $clog2(CMAX + 1);
  localparam int SW   = (IW > AW + 1) ? IW + 1 : AW + 2;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    FIN,
    WARM
  } state_t;

  state_t state, state_nxt;

  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] emitted;
  logic [IW-1:0]    in_flight;
  logic [AW:0]      count;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [15:0]      mem [FIFO_DEPTH];
  logic             aborting;
  logic             err_q;
  logic             done_q;

  logic          accept;
  logic          abort_now;
  logic          credit_ok;
  logic [SW-1:0] occ;
  logic          full;
  logic          pop;
  logic          ret;
  logic          discard;
  logic          wr;
  logic          err_set;

`ifdef GNG_WARMUP_EN
  localparam int WW = $clog2(WARMUP + 1);
  logic [WW-1:0] warm_cnt;
`endif

  assign accept    = req_valid && req_ready;
  assign abort_now = abort && (state == RUN || state == DRAIN);
  assign occ       = SW'(count) + SW'(in_flight);
  assign credit_ok = occ < SW'(FIFO_DEPTH);
  assign full      = count == (AW+1)'(FIFO_DEPTH);
  assign pop       = m_valid && m_ready && !abort_now;
  assign ret       = gng_valid && (in_flight != '0);
  // Returns owed to an aborted burst or to warm-up are swallowed silently
  assign discard   = aborting || abort_now || state == WARM;
  assign wr        = ret && !discard && (!full || pop);
  assign err_set   = gng_valid &&
                     ((in_flight == '0) || (!discard && full && !pop));

  assign m_valid = count != '0;
  assign m_data  = mem[rd_ptr];
  assign m_last  = m_valid && !aborting && (emitted == len_q - 1'b1);
  assign busy    = state != IDLE;
  assign done    = done_q;
  assign err     = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
`ifdef GNG_WARMUP_EN
      state <= WARM;
`else
      state <= IDLE;
`endif
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gng_ce    = 1'b0;
    req_ready = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_nxt = (req_len == '0) ? FIN : RUN;
      end
      RUN: begin
        gng_ce = !abort && (issued < len_q) && credit_ok;
        if (abort || issued == len_q)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!abort && in_flight == '0 && count == '0)
          state_nxt = FIN;
      end
      FIN: state_nxt = IDLE;
      WARM: begin
`ifdef GNG_WARMUP_EN
        gng_ce = warm_cnt < WW'(WARMUP);
        if (warm_cnt == WW'(WARMUP) && in_flight == '0)
          state_nxt = IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      len_q   <= '0;
      issued  <= '0;
      emitted <= '0;
    end else if (accept) begin
      len_q   <= req_len;
      issued  <= '0;
      emitted <= '0;
    end else begin
      if (gng_ce && state == RUN)
        issued <= issued + 1'b1;
      if (pop)
        emitted <= emitted + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      in_flight <= '0;
    else
      in_flight <= in_flight + IW'(gng_ce) - IW'(ret);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else if (wr) begin
      mem[wr_ptr] <= gng_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      aborting <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      if (abort_now)
        aborting <= 1'b1;
      else if (state == FIN)
        aborting <= 1'b0;
      if (err_set)
        err_q <= 1'b1;
      done_q <= state == FIN;
    end
  end

`ifdef GNG_WARMUP_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      warm_cnt <= '0;
    else if (gng_ce && state == WARM)
      warm_cnt <= warm_cnt + 1'b1;
  end
`endif

endmodule

// File: tb/tb_gng_burst_ctrl.sv
// Bench for gng_burst_ctrl: gng latency model, scoreboard of issued samples, directed bursts.
// Honours GNG_WARMUP_EN when the DUT is built with it.
module tb_gng_burst_ctrl;

  localparam int LAT = 6;
`ifdef GNG_WARMUP_EN
  localparam bit WARM_EN = 1'b1;
`else
  localparam bit WARM_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [15:0] req_len = '0;
  logic        abort = 1'b0;
  logic        gng_ce;
  logic        gng_valid = 1'b0;
  logic [15:0] gng_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        m_last;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  gng_burst_ctrl dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_len   (req_len),
    .abort     (abort),
    .gng_ce    (gng_ce),
    .gng_valid (gng_valid),
    .gng_data  (gng_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  typedef struct {
    int unsigned due;
    logic [15:0] d;
  } pend_t;

  pend_t       pipe_q[$];
  logic [15:0] exp_q[$];
  int unsigned cyc = 0;
  bit          inj = 1'b0;
  bit          warm_phase = WARM_EN;
  bit          ce_seen = 1'b0;
  logic [15:0] d_seen = '0;
  int checks = 0;
  int failures = 0;
  int ce_cnt = 0;
  int mv_cnt = 0;
  int done_cnt = 0;
  int bt_cnt = 0;
  int last_cnt = 0;
  int beat = 0;
  int cur_len = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // gng model: each ce returns one sample LAT cycles later
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (ce_seen)
      pipe_q.push_back('{cyc + LAT - 1, d_seen});
    #1;
    if (!rstn) begin
      pipe_q.delete();
      gng_valid = 1'b0;
      gng_data  = '0;
    end else if (pipe_q.size() > 0 && pipe_q[0].due == cyc) begin
      gng_data  = pipe_q[0].d;
      gng_valid = 1'b1;
      void'(pipe_q.pop_front());
    end else begin
      gng_valid = inj;
      gng_data  = 16'hdead;
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    ce_seen = 1'b0;
    if (!rstn) begin
      exp_q.delete();
    end else begin
      if (req_valid && req_ready) begin
        cur_len = int'(req_len);
        beat = 0;
      end
      if (gng_ce) begin
        ce_cnt++;
        ce_seen = 1'b1;
        d_seen = 16'($urandom);
        if (!warm_phase)
          exp_q.push_back(d_seen);
      end
      if (m_valid)
        mv_cnt++;
      if (done)
        done_cnt++;
      if (m_valid && m_ready && !abort) begin
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("m_data", m_data, e);
          check("m_last", m_last, beat == cur_len - 1);
        end
        if (m_last)
          last_cnt++;
        beat++;
        bt_cnt++;
      end
      if (abort && busy)
        exp_q.delete();
    end
  end

  task automatic do_req(input int l);
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_len   = 16'(l);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000; i++) begin
      if (done_cnt >= target)
        break;
      @(posedge clk); #1;
    end
    check("done_timeout", done_cnt >= target, 1);
  endtask

  initial begin
    int c0, b0, d0, l0, m0, ca;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, !WARM_EN);
    check("rst_gng_ce", gng_ce, WARM_EN);
    check("rst_m_valid", m_valid, 0);
    check("rst_busy", busy, WARM_EN);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    @(posedge clk); #1;
    rstn = 1'b1;

    if (WARM_EN) begin
      for (int i = 0; i < 1000; i++) begin
        if (req_ready)
          break;
        @(posedge clk); #1;
      end
      check("warm_ready", req_ready, 1);
      check("warm_ce_cnt", ce_cnt, 64);
      check("warm_m_valid", mv_cnt, 0);
      check("warm_err", err, 0);
      warm_phase = 1'b0;
    end else begin
      check("idle_ready", req_ready, 1);
    end

    // len=8 at full throughput
    m_ready = 1'b1;
    c0 = ce_cnt; b0 = bt_cnt; d0 = done_cnt; l0 = last_cnt;
    do_req(8);
    wait_done(d0 + 1);
    repeat (4) @(posedge clk);
    #1;
    check("b8_ce", ce_cnt - c0, 8);
    check("b8_beats", bt_cnt - b0, 8);
    check("b8_last", last_cnt - l0, 1);
    check("b8_done", done_cnt - d0, 1);
    check("b8_err", err, 0);
    check("b8_sb_empty", exp_q.size(), 0);
    check("b8_busy", busy, 0);

    // len=40 with downstream stalled: credits cap issue at FIFO depth
    m_ready = 1'b0;
    c0 = ce_cnt; b0 = bt_cnt; d0 = done_cnt; l0 = last_cnt;
    do_req(40);
    repeat (100) @(posedge clk);
    #1;
    check("b40_ce_cap", ce_cnt - c0, 16);
    check("b40_m_valid", m_valid, 1);
    check("b40_stall_data", m_data, exp_q[0]);
    check("b40_err_stall", err, 0);
    m_ready = 1'b1;
    wait_done(d0 + 1);
    repeat (4) @(posedge clk);
    #1;
    check("b40_ce", ce_cnt - c0, 40);
    check("b40_beats", bt_cnt - b0, 40);
    check("b40_last", last_cnt - l0, 1);
    check("b40_done", done_cnt - d0, 1);
    check("b40_err", err, 0);
    check("b40_sb_empty", exp_q.size(), 0);

    // zero-length burst
    c0 = ce_cnt; m0 = mv_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_len   = '0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("z_busy", busy, 1);
    check("z_done_c1", done, 0);
    @(posedge clk); #1;
    check("z_done_c2", done, 1);
    check("z_idle", busy, 0);
    @(posedge clk); #1;
    check("z_done_c3", done, 0);
    repeat (3) @(posedge clk);
    #1;
    check("z_ce", ce_cnt - c0, 0);
    check("z_m_valid", mv_cnt - m0, 0);
    check("z_ready", req_ready, 1);

    // len=20 aborted after 10 beats
    m_ready = 1'b1;
    c0 = ce_cnt; b0 = bt_cnt; d0 = done_cnt; l0 = last_cnt;
    do_req(20);
    for (int i = 0; i < 200; i++) begin
      if (bt_cnt - b0 >= 10)
        break;
      @(posedge clk); #1;
    end
    check("ab_beats", bt_cnt - b0, 10);
    m_ready = 1'b0;
    abort   = 1'b1;
    #1;
    check("ab_ce_forced", gng_ce, 0);
    check("ab_ce_partial", ce_cnt - c0 < 20, 1);
    ca = ce_cnt;
    @(posedge clk); #1;
    abort = 1'b0;
    check("ab_flushed", m_valid, 0);
    m0 = mv_cnt;
    wait_done(d0 + 1);
    repeat (6) @(posedge clk);
    #1;
    check("ab_no_valid", mv_cnt - m0, 0);
    check("ab_no_ce", ce_cnt - ca, 0);
    check("ab_done", done_cnt - d0, 1);
    check("ab_no_last", last_cnt - l0, 0);
    check("ab_err", err, 0);
    check("ab_busy", busy, 0);

    // stray gng_valid in IDLE sets sticky err
    m_ready = 1'b1;
    @(negedge clk);
    inj = 1'b1;
    @(negedge clk);
    inj = 1'b0;
    @(posedge clk); #1;
    check("err_set", err, 1);
    c0 = ce_cnt; b0 = bt_cnt; d0 = done_cnt;
    do_req(8);
    wait_done(d0 + 1);
    repeat (3) @(posedge clk);
    #1;
    check("err_b8_beats", bt_cnt - b0, 8);
    check("err_sticky", err, 1);
    rstn = 1'b0;
    #1;
    check("err_rst", err, 0);
    check("rst2_busy", busy, WARM_EN);
    check("rst2_m_valid", m_valid, 0);
    check("rst2_ready", req_ready, !WARM_EN);
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
